mac_ctrl: RTL
=============

# mac_ctrl

Job sequencer for the 16-lane 8-bit dot-product MAC (128-bit pixel and weight vectors in, 20-bit sum out). It accepts a job of `len` 16-element chunks and streams the chunks into the MAC at up to one per cycle. It accumulates the MAC sums across the job, then returns the full accumulator and a shifted, saturated 8-bit output pixel through a valid/ready result port. It sits between the line/weight buffers and the output writer of the convolution layer.

## Interface
- `ACC_W`, default 32: accumulator width, minimum 20.
- `CNT_W`, default 8: width of the chunk count `len`.
- `MAC_LAT`, default 2: clock edges from a chunk being registered onto `mac_pixels`/`mac_weights` to the edge where the matching `mac_sum` is accumulated.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle job request; honoured only in IDLE.
- `len` in CNT_W: chunks in the job; latched on an accepted start.
- `shift` in 5: right-shift for `res_pix`; latched on an accepted start.
- `busy` out 1: high in every state except IDLE.
- `chunk_valid` in 1: buffer has a chunk on `pixels_in`/`weights_in`.
- `chunk_ready` out 1: controller accepts a chunk this cycle.
- `pixels_in` in 128: 16 unsigned 8-bit pixels.
- `weights_in` in 128: 16 unsigned 8-bit weights.
- `mac_pixels` out 128: registered pixel vector driven to the MAC.
- `mac_weights` out 128: registered weight vector driven to the MAC.
- `mac_sum` in 20: MAC dot-product output.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_acc` out ACC_W: accumulated dot product.
- `res_pix` out 8: min(`res_acc` >> `shift`, 255).

## Operation
- **States:**
  - IDLE: `chunk_ready`=0 and `res_valid`=0.
  - RUN: chunks are accepted.
  - DRAIN: in-flight sums complete.
  - DONE: `res_valid`=1.
- **IDLE:**
  - When `start`=1 and `len`≠0: latch `len` and `shift`, clear the accumulator, clear the issued counter, go to RUN.
  - When `start`=1 and `len`=0: latch `shift`, clear the accumulator, go directly to DONE.
- **RUN:**
  - `chunk_ready` = (issued < len).
  - Accept when `chunk_valid` && `chunk_ready`.
  - On an accept: register the inputs onto `mac_pixels`/`mac_weights`, increment issued, and push a 1 into a MAC_LAT-deep valid delay line. Otherwise push a 0.
  - Move to DRAIN on the edge that accepts the last chunk.
- **Accumulation:** on every edge where the delay-line output is 1, acc ← acc + zero-extended `mac_sum`. This applies in RUN and DRAIN.
- **DRAIN:** `chunk_ready`=0. Go to DONE on the edge where the final in-flight sum is accumulated, i.e. when the delay line becomes empty.
- **DONE:**
  - `res_acc` and `res_pix` are held stable while `res_valid`=1.
  - On `res_valid` && `res_ready`, go to IDLE.
  - A `start` in that same cycle is ignored; the next job starts at the earliest in the following IDLE cycle.
- **Width and saturation:**
  - Accumulator saturation is sticky at 2^ACC_W−1; it does not wrap.
  - `res_pix` is combinational from the latched shift and accumulator, and saturates at 255.
- **Ignored inputs:**
  - `start` is ignored while `busy`=1.
  - `chunk_valid` is ignored unless `chunk_ready`=1.
  - Surplus chunks beyond `len` are never accepted.
- `mac_pixels`/`mac_weights` hold their last value when no chunk is accepted. Their data is meaningful only where the delay line marks it valid.

## Timing
- **Reset values:**
  - State is IDLE.
  - `busy`, `chunk_ready`, `res_valid` = 0.
  - `res_acc`, `res_pix`, `mac_pixels`, `mac_weights`, the counters and the delay line = 0.
- **Reset mid-job:** takes effect immediately. All in-flight sums are discarded and the partial accumulator is lost. No result is emitted.
- **Throughput:** one chunk per cycle with no bubbles when `chunk_valid` stays high.
- **Latency without stalls:** first accept at edge t, last at edge t+len−1. The last sum is accumulated at edge t+len−1+MAC_LAT. `res_valid` rises at that edge (t+len+1 for MAC_LAT=2).
- **Zero-length job:** `start` with `len`=0 at edge s gives `res_valid` high from edge s.
- **Stalls:** source stalls (`chunk_valid` low) delay completion cycle-for-cycle. A result stall (`res_ready` low) holds DONE indefinitely.

## Test plan
- **Single chunk:** `len`=1, `shift`=0, all pixels 1, all weights 2, accepted at edge t -> `res_valid` at edge t+2, `res_acc`=32, `res_pix`=32; `busy` drops after the handshake.
- **Full-scale accumulation:** `len`=4, every pixel and weight 255, `shift`=16 -> `res_acc`=4,161,600 and `res_pix`=63. Repeat with `shift`=0 -> `res_pix`=255.
- **Stalls:** `len`=3, `chunk_valid` low for 2 cycles between each chunk, `res_ready` low for 5 cycles. `start` pulses while busy. Expected:
  - exactly 3 accepts;
  - results stable through the stall;
  - `start` ignored;
  - sum matches the reference dot product.
- **Zero-length job:** `len`=0 -> `res_valid` on the edge after start, `res_acc`=0, no `chunk_ready` pulse.
- **Reset mid-job:** `rst_n` low after 2 of 4 chunks. Expected:
  - all outputs at their reset values;
  - a subsequent `len`=2 job (pixels 3, weights 4) returns 384.
- **Saturation:** `ACC_W`=21, `len`=3, all 255 -> true sum 3,121,200 clamps to `res_acc`=2,097,151, with no wrap.

Source files
------------

// File: rtl/mac_ctrl.sv
// mac_ctrl: job sequencer for the 16-lane 8-bit dot-product MAC.
// Accepts a job of `len` 128-bit chunk pairs, streams them into the MAC at up
// to one per cycle, accumulates the returned sums with sticky saturation and
// presents the accumulator plus a shifted, clamped 8-bit pixel on a
// valid/ready result port.
module mac_ctrl #(
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [4:0]       shift,
    output logic             busy,
    input  logic             chunk_valid,
    output logic             chunk_ready,
    input  logic [127:0]     pixels_in,
    input  logic [127:0]     weights_in,
    output logic [127:0]     mac_pixels,
    output logic [127:0]     mac_weights,
    input  logic [19:0]      mac_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_acc,
    output logic [7:0]       res_pix
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // All delay-line stages except the output stage; once these are clear
    // the sum leaving the line this cycle is the last one in flight.
    localparam logic [MAC_LAT-1:0] PIPE_LOW = {MAC_LAT{1'b1}} >> 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   len_reg;
    logic [CNT_W-1:0]   issued_reg;
    logic [4:0]         shift_reg;
    logic               busy_reg;
    logic               chunk_ready_reg;
    logic               res_valid_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [127:0]       mac_pixels_reg;
    logic [127:0]       mac_weights_reg;
    logic [MAC_LAT-1:0] vld_pipe_reg;
    logic [MAC_LAT-1:0] vld_pipe_next;

    logic               accept;
    logic               last_accept;
    logic               pipe_out;
    logic               pipe_drained;
    logic [ACC_W:0]     acc_sum;
    logic [ACC_W-1:0]   acc_shifted;

    // A chunk moves only in RUN while the controller still wants one.
    assign accept      = (state_reg == RUN) && chunk_valid && chunk_ready_reg;
    assign last_accept = accept && (issued_reg == (len_reg - CNT_W'(1)));

    // Valid delay line: stage 0 records this cycle's accept, the others shift.
    assign vld_pipe_next[0] = accept;
    genvar gi;
    generate
        for (gi = 1; gi < MAC_LAT; gi++) begin : g_vld_pipe
            assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
        end
    endgenerate

    assign pipe_out     = vld_pipe_reg[MAC_LAT-1];
    assign pipe_drained = (vld_pipe_reg & PIPE_LOW) == '0;

    // One extra bit catches the carry so overflow clamps instead of wrapping.
    assign acc_sum = {1'b0, acc_reg} + {{(ACC_W-19){1'b0}}, mac_sum};

    // Job sequencing: state, latched job parameters and registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            issued_reg      <= '0;
            shift_reg       <= '0;
            busy_reg        <= 1'b0;
            chunk_ready_reg <= 1'b0;
            res_valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg <= shift;
                        busy_reg  <= 1'b1;
                        if (len != '0) begin
                            len_reg         <= len;
                            issued_reg      <= '0;
                            chunk_ready_reg <= 1'b1;
                            state_reg       <= RUN;
                        end else begin
                            // Nothing to compute: the cleared accumulator is the result.
                            res_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        issued_reg <= issued_reg + CNT_W'(1);
                        if (last_accept) begin
                            chunk_ready_reg <= 1'b0;
                            state_reg       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave on the same edge that folds in the final sum.
                    if (pipe_drained) begin
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Operand registers toward the MAC; they hold between accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_pixels_reg  <= '0;
            mac_weights_reg <= '0;
        end else if (accept) begin
            mac_pixels_reg  <= pixels_in;
            mac_weights_reg <= weights_in;
        end
    end

    // Valid delay line tracking which MAC outputs belong to accepted chunks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_reg <= '0;
        end else begin
            vld_pipe_reg <= vld_pipe_next;
        end
    end

    // Accumulator: cleared on job start, adds each valid MAC sum, sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            acc_reg <= '0;
        end else if (pipe_out) begin
            acc_reg <= acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        end
    end

    // Output pixel: shifted accumulator clamped to 8 bits.
    assign acc_shifted = acc_reg >> shift_reg;
    assign res_pix     = (acc_shifted > ACC_W'(255)) ? 8'hFF : acc_shifted[7:0];

    assign busy        = busy_reg;
    assign chunk_ready = chunk_ready_reg;
    assign res_valid   = res_valid_reg;
    assign res_acc     = acc_reg;
    assign mac_pixels  = mac_pixels_reg;
    assign mac_weights = mac_weights_reg;

endmodule
